// File: rtl/or1200_enc_arbiter_pkg.sv
// Shared encodings for the encryption-engine arbiter: FSM states, modes, owners.
package or1200_enc_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStart   = 2'd1,
    StWait    = 2'd2,
    StUnstall = 2'd3
  } enc_state_e;

  localparam logic EncModeDec = 1'b0;
  localparam logic EncModeEnc = 1'b1;

  localparam logic OwnIc = 1'b0;
  localparam logic OwnDc = 1'b1;

  localparam int unsigned GrantW = 2;

  // Owner code to the one-hot {dc,ic} grant vector.
  function automatic logic [GrantW-1:0] owner_onehot(input logic owner);
    return (owner == OwnDc) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/or1200_enc_arbiter_if.sv
// Request/engine/status bundle between the cache sides, the engine and the arbiter.
interface or1200_enc_arbiter_if
  import or1200_enc_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32
);
  logic              ic_req_i;
  logic [AW-1:0]     ic_addr_i;
  logic              dc_req_i;
  logic [AW-1:0]     dc_addr_i;
  logic              dc_we_i;
  logic              ic_unstall_o;
  logic              dc_unstall_o;
  logic              enc_start_o;
  logic [AW-1:0]     enc_addr_o;
  logic              enc_mode_o;
  logic              enc_done_i;
  logic              enc_abort_o;
  logic [GrantW-1:0] grant_o;
  logic              err_o;
  logic              err_src_o;
  logic              err_clr_i;

  // Arbiter side.
  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_addr_i, dc_we_i, enc_done_i, err_clr_i,
    output ic_unstall_o, dc_unstall_o, enc_start_o, enc_addr_o, enc_mode_o, enc_abort_o,
    output grant_o, err_o, err_src_o
  );

  // Requesters, engine and error-status consumer.
  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_addr_i, dc_we_i, enc_done_i, err_clr_i,
    input  ic_unstall_o, dc_unstall_o, enc_start_o, enc_addr_o, enc_mode_o, enc_abort_o,
    input  grant_o, err_o, err_src_o
  );
endinterface

// File: rtl/or1200_enc_wdt.sv
// Engine watchdog: clearable, enabled, saturating counter with a registered expiry flag.
module or1200_enc_wdt #(
  parameter int unsigned   TW      = 8,
  parameter logic [TW-1:0] TIMEOUT = 8'd200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam logic [TW-1:0] ExpVal = TIMEOUT - 1'b1;

  logic [TW-1:0] cnt_q, cnt_d;
  logic          expired_q;

  // Next count: clear dominates, increment only while enabled and below all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {TW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expiry is compared on the next count so the flag lines up with the count it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == ExpVal);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/or1200_enc_arbiter.sv
// Round-robin arbiter sharing one line-encryption engine between the IC and DC paths.
module or1200_enc_arbiter
  import or1200_enc_arbiter_pkg::*;
#(
  parameter int unsigned   AW      = 32,
  parameter int unsigned   TW      = 8,
  parameter logic [TW-1:0] TIMEOUT = 8'd200
) (
  input logic                 clk,
  input logic                 rst,
  or1200_enc_arbiter_if.slave bus
);

  enc_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [GrantW-1:0] grant_q, grant_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              err_src_q, err_src_d;

  logic pick_dc;
  logic enc_start, enc_abort, ic_unstall, dc_unstall;
  logic wdt_clr, wdt_en, wdt_expired;

  or1200_enc_wdt #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wdt_clr),
    .en_i      (wdt_en),
    .expired_o (wdt_expired)
  );

  // Next-state, latches and one-cycle pulses for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    err_d      = err_q;
    err_src_d  = err_src_q;
    pick_dc    = 1'b0;
    enc_start  = 1'b0;
    enc_abort  = 1'b0;
    ic_unstall = 1'b0;
    dc_unstall = 1'b0;
    wdt_clr    = 1'b0;
    wdt_en     = 1'b0;

    // Clear first so a timeout later in this block overrides it.
    if (bus.err_clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.ic_req_i || bus.dc_req_i) begin
          // On a tie the side not served last wins.
          pick_dc = bus.dc_req_i && (!bus.ic_req_i || (last_q == OwnIc));
          owner_d = pick_dc ? OwnDc : OwnIc;
          addr_d  = pick_dc ? bus.dc_addr_i : bus.ic_addr_i;
          mode_d  = (pick_dc && bus.dc_we_i) ? EncModeEnc : EncModeDec;
          grant_d = owner_onehot(owner_d);
          state_d = StStart;
        end
      end
      StStart: begin
        enc_start = 1'b1;
        wdt_clr   = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        wdt_en = 1'b1;
        if (bus.enc_done_i) begin
          state_d = StUnstall;
        end else if (wdt_expired) begin
          // Release the requester anyway so a hung engine cannot deadlock a cache.
          enc_abort = 1'b1;
          err_d     = 1'b1;
          err_src_d = owner_q;
          state_d   = StUnstall;
        end
      end
      StUnstall: begin
        ic_unstall = (owner_q == OwnIc);
        dc_unstall = (owner_q == OwnDc);
        last_d     = owner_q;
        grant_d    = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset drops any transaction without signalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnIc;
      last_q    <= OwnDc;
      grant_q   <= '0;
      addr_q    <= '0;
      mode_q    <= EncModeDec;
      err_q     <= 1'b0;
      err_src_q <= OwnIc;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

  assign bus.enc_start_o  = enc_start;
  assign bus.enc_abort_o  = enc_abort;
  assign bus.ic_unstall_o = ic_unstall;
  assign bus.dc_unstall_o = dc_unstall;
  assign bus.grant_o      = grant_q;
  assign bus.enc_addr_o   = addr_q;
  assign bus.enc_mode_o   = mode_q;
  assign bus.err_o        = err_q;
  assign bus.err_src_o    = err_src_q;

endmodule

// File: tb/tb_or1200_enc_arbiter.sv
// Self-checking bench for or1200_enc_arbiter: vector tables, corner sequences, random traffic.
module tb_or1200_enc_arbiter;
  localparam int unsigned   AW      = 32;
  localparam int unsigned   TW      = 8;
  localparam logic [TW-1:0] TIMEOUT = 8'd200;
  localparam int            TO      = 200;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] A_IC  = 32'h0000_1040;
  localparam logic [31:0] A_B   = 32'h0000_2000;
  localparam logic [31:0] A_C   = 32'h0000_4000;
  localparam logic [31:0] A_D   = 32'h8000_0040;
  localparam logic [31:0] A_X   = 32'hdead_0000;
  localparam logic [31:0] A_DCT = 32'hcafe_0080;
  localparam logic [31:0] A_E   = 32'h0bad_0100;
  localparam logic [31:0] ZERO  = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  or1200_enc_arbiter_if #(.AW(AW)) bus ();

  or1200_enc_arbiter #(
    .AW      (AW),
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic        dc_we;
    logic        done;
    logic        e_start;
    logic [1:0]  e_grant;
    logic        e_icu;
    logic        e_dcu;
    logic [31:0] e_addr;
    logic        e_mode;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(logic ir, logic [31:0] ia, logic dr, logic [31:0] da, logic we,
                               logic dn, logic s, logic [1:0] g, logic iu, logic du,
                               logic [31:0] ea, logic em);
    vec_t v;
    v = '{ir, ia, dr, da, we, dn, s, g, iu, du, ea, em};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic we, input logic dn, input logic clr);
    rst            = r;
    bus.ic_req_i   = ir;
    bus.ic_addr_i  = ia;
    bus.dc_req_i   = dr;
    bus.dc_addr_i  = da;
    bus.dc_we_i    = we;
    bus.enc_done_i = dn;
    bus.err_clr_i  = clr;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs at the falling edge of the current cycle.
  task automatic cyc(input string tag, input logic e_start, input logic [1:0] e_grant,
                     input logic e_icu, input logic e_dcu, input logic e_abort, input logic e_err,
                     input logic e_src, input logic chk_am, input logic [31:0] e_addr,
                     input logic e_mode);
    @(negedge clk);
    check({tag, " enc_start"}, 32'(bus.enc_start_o), 32'(e_start));
    check({tag, " grant"}, 32'(bus.grant_o), 32'(e_grant));
    check({tag, " ic_unstall"}, 32'(bus.ic_unstall_o), 32'(e_icu));
    check({tag, " dc_unstall"}, 32'(bus.dc_unstall_o), 32'(e_dcu));
    check({tag, " enc_abort"}, 32'(bus.enc_abort_o), 32'(e_abort));
    check({tag, " err"}, 32'(bus.err_o), 32'(e_err));
    check({tag, " err_src"}, 32'(bus.err_src_o), 32'(e_src));
    if (chk_am) begin
      check({tag, " enc_addr"}, bus.enc_addr_o, e_addr);
      check({tag, " enc_mode"}, 32'(bus.enc_mode_o), 32'(e_mode));
    end
  endtask

  task automatic do_reset();
    set_in(H, L, ZERO, L, ZERO, L, L, L);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = L;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      set_in(L, tbl[i].ic_req, tbl[i].ic_addr, tbl[i].dc_req, tbl[i].dc_addr, tbl[i].dc_we,
             tbl[i].done, L);
      cyc($sformatf("%s[%0d]", tag, i), tbl[i].e_start, tbl[i].e_grant, tbl[i].e_icu,
          tbl[i].e_dcu, L, L, L, H, tbl[i].e_addr, tbl[i].e_mode);
      next();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          m_g, m_u, done_at;
    logic        m_busy, m_owner, m_last, m_err, m_src, m_mode, set_err;
    logic [31:0] m_addr;
    logic        s_icu, s_dcu, s_start;
    logic        e_start, e_icu, e_dcu, e_abort;
    logic [1:0]  e_grant;

    // IC-only decrypt; first row also checks the reset state.
    do_reset();
    tbl.delete();
    //                 ir ia    dr da    we dn  start grant  icu dcu addr  mode
    tbl.push_back(row(H, A_IC, L, ZERO, L, L, L, 2'b00, L, L, ZERO, L));
    tbl.push_back(row(H, A_IC, L, ZERO, L, L, H, 2'b01, L, L, A_IC, L));
    tbl.push_back(row(H, A_IC, L, ZERO, L, L, L, 2'b01, L, L, A_IC, L));
    tbl.push_back(row(H, A_IC, L, ZERO, L, L, L, 2'b01, L, L, A_IC, L));
    tbl.push_back(row(H, A_IC, L, ZERO, L, L, L, 2'b01, L, L, A_IC, L));
    tbl.push_back(row(H, A_IC, L, ZERO, L, H, L, 2'b01, L, L, A_IC, L));
    tbl.push_back(row(H, A_IC, L, ZERO, L, L, L, 2'b01, H, L, A_IC, L));
    tbl.push_back(row(L, A_IC, L, ZERO, L, L, L, 2'b00, L, L, A_IC, L));
    run_table("ic_only");

    // Ties, round-robin, spurious done in IDLE/START, address churn in WAIT.
    do_reset();
    tbl.delete();
    tbl.push_back(row(H, A_B, H, A_D, H, H, L, 2'b00, L, L, ZERO, L));
    tbl.push_back(row(H, A_B, H, A_D, H, H, H, 2'b01, L, L, A_B, L));
    tbl.push_back(row(H, A_X, H, A_D, H, L, L, 2'b01, L, L, A_B, L));
    tbl.push_back(row(H, A_X, H, A_D, H, H, L, 2'b01, L, L, A_B, L));
    tbl.push_back(row(H, A_X, H, A_D, H, L, L, 2'b01, H, L, A_B, L));
    tbl.push_back(row(L, A_X, H, A_D, H, L, L, 2'b00, L, L, A_B, L));
    tbl.push_back(row(L, A_X, H, A_D, H, L, H, 2'b10, L, L, A_D, H));
    tbl.push_back(row(L, A_X, H, A_D, H, H, L, 2'b10, L, L, A_D, H));
    tbl.push_back(row(L, A_X, H, A_D, H, L, L, 2'b10, L, H, A_D, H));
    tbl.push_back(row(L, A_X, L, A_D, H, L, L, 2'b00, L, L, A_D, H));
    tbl.push_back(row(H, A_B, H, A_D, L, L, L, 2'b00, L, L, A_D, H));
    tbl.push_back(row(H, A_B, H, A_D, L, L, H, 2'b01, L, L, A_B, L));
    tbl.push_back(row(H, A_B, H, A_D, L, H, L, 2'b01, L, L, A_B, L));
    tbl.push_back(row(H, A_B, H, A_D, L, L, L, 2'b01, H, L, A_B, L));
    tbl.push_back(row(L, A_B, H, A_D, L, L, L, 2'b00, L, L, A_B, L));
    tbl.push_back(row(L, A_B, H, A_D, L, L, H, 2'b10, L, L, A_D, L));
    run_table("tie_rr");

    // DC timeout: expiry on the 200th WAIT cycle.
    do_reset();
    for (int c = 0; c <= 203; c++) begin
      set_in(L, L, ZERO, (c <= 202), A_DCT, L, L, L);
      cyc($sformatf("timeout_dc c%0d", c), (c == 1), (c >= 1 && c <= 202) ? 2'b10 : 2'b00,
          L, (c == 202), (c == 201), (c >= 202), (c >= 202), (c >= 1), A_DCT, L);
      next();
    end

    // Clear error, then done lands exactly on the expiry cycle: no abort, no error.
    for (int b = 0; b <= 204; b++) begin
      set_in(L, (b >= 1 && b <= 203), A_B, L, ZERO, L, (b == 202), (b == 0));
      cyc($sformatf("done_vs_to b%0d", b), (b == 2), (b >= 2 && b <= 203) ? 2'b01 : 2'b00,
          (b == 203), L, L, (b == 0), H, (b >= 2), A_B, L);
      next();
    end

    // IC timeout with err_clr in the same cycle: set wins, source becomes IC.
    for (int c = 0; c <= 203; c++) begin
      set_in(L, (c <= 202), A_C, L, ZERO, L, L, (c == 201));
      cyc($sformatf("set_vs_clr c%0d", c), (c == 1), (c >= 1 && c <= 202) ? 2'b01 : 2'b00,
          (c == 202), L, (c == 201), (c >= 202), (c < 202), (c >= 1), A_C, L);
      next();
    end

    // Reset on WAIT cycle 3 of a DC transaction, then a tie goes to IC.
    for (int d = 0; d <= 11; d++) begin
      set_in((d == 5), (d >= 7 && d <= 10), A_IC, (d <= 5 || d >= 7), A_E, H, (d == 9), L);
      case (d)
        0:       cyc("rst_wait d0", L, 2'b00, L, L, L, H, L, L, ZERO, L);
        1:       cyc("rst_wait d1", H, 2'b10, L, L, L, H, L, H, A_E, H);
        2, 3, 4: cyc("rst_wait d2-4", L, 2'b10, L, L, L, H, L, H, A_E, H);
        5:       cyc("rst_wait d5", L, 2'b10, L, L, L, H, L, H, A_E, H);
        6, 7:    cyc("rst_wait d6-7", L, 2'b00, L, L, L, L, L, H, ZERO, L);
        8:       cyc("rst_wait d8", H, 2'b01, L, L, L, L, L, H, A_IC, L);
        9:       cyc("rst_wait d9", L, 2'b01, L, L, L, L, L, H, A_IC, L);
        10:      cyc("rst_wait d10", L, 2'b01, H, L, L, L, L, H, A_IC, L);
        default: cyc("rst_wait d11", L, 2'b00, L, L, L, L, L, H, A_IC, L);
      endcase
      next();
    end

    // Random traffic against a timestamp-based transaction model.
    do_reset();
    m_busy = L; m_g = 0; m_u = -1; m_owner = L; m_last = H;
    m_err = L; m_src = L; m_addr = ZERO; m_mode = L;
    s_icu = L; s_dcu = L; s_start = L; done_at = -1;
    for (int c = 0; c < 3000; c++) begin
      if (s_icu) bus.ic_req_i = L;
      else if (!bus.ic_req_i && $urandom_range(0, 3) == 0) begin
        bus.ic_req_i  = H;
        bus.ic_addr_i = $urandom;
      end
      if (s_dcu) bus.dc_req_i = L;
      else if (!bus.dc_req_i && $urandom_range(0, 3) == 0) begin
        bus.dc_req_i  = H;
        bus.dc_addr_i = $urandom;
        bus.dc_we_i   = 1'($urandom_range(0, 1));
      end
      if (s_start) done_at = c + int'($urandom_range(0, 10));
      if (c == done_at) bus.enc_done_i = H;
      else bus.enc_done_i = (done_at < c) && ($urandom_range(0, 7) == 0);
      bus.err_clr_i = ($urandom_range(0, 15) == 0);

      e_start = m_busy && (c == m_g + 1);
      e_grant = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      e_icu   = m_busy && (c == m_u) && !m_owner;
      e_dcu   = m_busy && (c == m_u) && m_owner;
      e_abort = m_busy && (m_u < 0) && !bus.enc_done_i && (c == m_g + 1 + TO);
      cyc($sformatf("rand c%0d", c), e_start, e_grant, e_icu, e_dcu, e_abort, m_err, m_src,
          H, m_addr, m_mode);
      s_icu   = bus.ic_unstall_o;
      s_dcu   = bus.dc_unstall_o;
      s_start = bus.enc_start_o;

      set_err = L;
      if (m_busy) begin
        if (c == m_u) begin
          m_busy = L;
          m_last = m_owner;
        end else if (m_u < 0 && c >= m_g + 2) begin
          if (bus.enc_done_i) m_u = c + 1;
          else if (c == m_g + 1 + TO) begin
            m_u     = c + 1;
            set_err = H;
            m_src   = m_owner;
          end
        end
      end else if (bus.ic_req_i || bus.dc_req_i) begin
        m_owner = (bus.ic_req_i && bus.dc_req_i) ? !m_last : bus.dc_req_i;
        m_addr  = m_owner ? bus.dc_addr_i : bus.ic_addr_i;
        m_mode  = m_owner && bus.dc_we_i;
        m_g     = c;
        m_u     = -1;
        m_busy  = H;
      end
      if (set_err) m_err = H;
      else if (bus.err_clr_i) m_err = L;
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
